ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the execute stage, fed by the ID/EX pipeline register. It performs MIPS-style MULT, MULTU, DIV and DIVU on two operands and holds the results in architectural HI/LO registers. While an operation runs, it raises a stall that freezes the upstream IF/ID and ID/EX registers by driving their En low. MTHI/MTLO-style direct writes to HI/LO are also supported.

---
 rtl/ex_muldiv.sv | 183 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and direct MTHI/MTLO writes.
// Latency: WIDTH+1 edges from the accepted Start to Done and the new Hi/Lo; direct writes land one edge later.
// Backpressure: Stall (Start | Busy) freezes the upstream pipeline registers; Start while Busy is dropped, not queued.
//
// Ports:
//   Clk, Rst          clock and synchronous active-high reset
//   Start, Op, A, B   issue request, opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), rs/rt operands
//   WrHi, WrLo, WrData direct HI/LO write, honoured only while idle
//   Busy, Stall, Done operation in progress, pipeline freeze, one-cycle completion pulse
//   Hi, Lo, DivZero   result registers and divide-by-zero flag of the last completed divide
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WrHi,
    input  logic             WrLo,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        cnt;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
    logic                 is_div;
    logic                 neg_lo;    // product / quotient must be negated
    logic                 neg_hi;    // remainder must be negated
    logic                 b_zero;

    // Operand preparation at issue
    logic                 sgn_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    assign sgn_op = ~Op[0];
    assign a_neg  = sgn_op & A[WIDTH-1];
    assign b_neg  = sgn_op & B[WIDTH-1];
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;

    assign Stall     = Start | Busy;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // One iteration step of either algorithm
    logic [WIDTH:0]   mul_sum;   // carry out of the upper-half add is kept for the right shift
    logic [WIDTH:0]   rem_sh;    // partial remainder shifted left with the next dividend bit
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_ge   = (rem_sh >= {1'b0, opnd});
        // Only used when rem_ge; the true difference is below the divisor, so W bits suffice
        rem_diff = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            acc_nxt = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction applied on the FIX edge
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = neg_lo ? -acc : acc;
        // A zero divisor leaves the dividend as remainder; only the quotient needs overriding
        quo  = b_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            b_zero  <= 1'b0;
        end else begin
            Done <= 1'b0;

            // Direct writes only while idle; a same-cycle Start result overwrites them later
            if (!Busy) begin
                if (WrHi) Hi <= WrData;
                if (WrLo) Lo <= WrData;
            end

            case (state)
                IDLE: begin
                    if (Start) begin
                        Busy    <= 1'b1;
                        DivZero <= 1'b0;
                        cnt     <= '0;
                        is_div  <= Op[1];
                        b_zero  <= Op[1] && (B == '0);
                        neg_lo  <= a_neg ^ b_neg;
                        if (Op[1]) begin
                            opnd   <= b_mag;
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            neg_hi <= a_neg;
                        end else begin
                            opnd   <= a_mag;
                            acc    <= {{WIDTH{1'b0}}, b_mag};
                            neg_hi <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    DivZero <= b_zero;
                    if (is_div) begin
                        Hi <= rem;
                        Lo <= quo;
                    end else begin
                        Hi <= prod[2*WIDTH-1:WIDTH];
                        Lo <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, multi-cycle corner sequences, random ops vs. arithmetic model.
// Latency: expects Done and results 33 edges after the issue edge.
// Backpressure: checks Stall/Busy over the whole operation and that Start/direct writes while busy are dropped.
module tb_ex_muldiv;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         WrHi;
    logic         WrLo;
    logic [W-1:0] WrData;
    logic         Busy;
    logic         Stall;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         DivZero;

    ex_muldiv #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .WrHi(WrHi), .WrLo(WrLo), .WrData(WrData),
        .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Bench-side view of the architectural registers
    logic [W-1:0] cur_hi;
    logic [W-1:0] cur_lo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: plain 64-bit arithmetic on the ISA rules
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint       sa;
        longint       sb;
        longint       sq;
        longint       sr;
        logic [63:0]  p;
        logic [63:0]  ua;
        logic [63:0]  ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else if (op == 2'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    p = sq; lo = p[31:0];
                    p = sr; hi = p[31:0];
                end else begin
                    p = ua / ub; lo = p[31:0];
                    p = ua % ub; hi = p[31:0];
                end
            end
        endcase
    endfunction

    // Issue one op (optionally with a same-cycle direct Hi write) and follow it to Done.
    // Called right after an edge, so it may be called in the Done cycle of the previous op.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input logic wr_hi, input logic [31:0] wr_dat);
        int  edges;
        logic hold_bad;
        Start = 1'b1; Op = op; A = a; B = b;
        WrHi = wr_hi; WrData = wr_dat;
        #1;
        chk({name, " stall_at_issue"}, Stall, 1);
        tick();
        Start = 1'b0; WrHi = 1'b0; A = $urandom; B = $urandom; Op = 2'($urandom);
        if (wr_hi) cur_hi = wr_dat;
        chk({name, " busy_after_issue"}, Busy, 1);
        chk({name, " done_low_after_issue"}, Done, 0);
        chk({name, " divzero_cleared"}, DivZero, 0);
        chk({name, " hi_after_issue"}, Hi, cur_hi);
        edges = 0;
        hold_bad = 1'b0;
        while (Done !== 1'b1 && edges < 100) begin
            if (Busy !== 1'b1 || Stall !== 1'b1 || Hi !== cur_hi || Lo !== cur_lo) hold_bad = 1'b1;
            tick();
            edges++;
        end
        chk({name, " hold_while_busy"}, hold_bad, 0);
        chk({name, " latency"}, edges, 33);
        chk({name, " busy_at_done"}, Busy, 0);
        chk({name, " stall_at_done"}, Stall, 0);
        chk({name, " hi"}, Hi, ehi);
        chk({name, " lo"}, Lo, elo);
        chk({name, " divzero"}, DivZero, edz);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        int          ndone;
        logic        seen;
        logic [31:0] mhi;
        logic [31:0] mlo;
        logic        mdz;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{2'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        tbl[4] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[6] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[7] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        tbl[8] = '{2'd3, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999, 1'b0};
        tbl[9] = '{2'd0, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};

        Rst = 1'b1; Start = 1'b0; Op = 2'd0; A = '0; B = '0;
        WrHi = 1'b0; WrLo = 1'b0; WrData = '0;
        tick();
        tick();
        Rst = 1'b0;
        chk("reset busy", Busy, 0);
        chk("reset done", Done, 0);
        chk("reset hi", Hi, 0);
        chk("reset lo", Lo, 0);
        chk("reset divzero", DivZero, 0);
        chk("reset stall", Stall, 0);
        cur_hi = '0;
        cur_lo = '0;

        // Directed table, issued back-to-back (each Start lands in the previous Done cycle)
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].hi, tbl[i].lo, tbl[i].dz, 1'b0, 32'd0);
        end
        tick();
        chk("done one cycle wide", Done, 0);

        // Direct writes while idle: one-edge latency
        WrHi = 1'b1; WrLo = 1'b1; WrData = 32'hCAFE_0001;
        tick();
        WrLo = 1'b0; WrData = 32'hBEEF_0002;
        chk("direct hi", Hi, 32'hCAFE_0001);
        chk("direct lo", Lo, 32'hCAFE_0001);
        cur_hi = 32'hCAFE_0001;
        WrHi = 1'b0; WrLo = 1'b1;
        tick();
        WrLo = 1'b0;
        chk("direct lo2", Lo, 32'hBEEF_0002);
        chk("direct hi kept", Hi, 32'hCAFE_0001);
        cur_lo = 32'hBEEF_0002;

        // DIV with Start and WrHi re-pulsed at k+5: both dropped, single Done
        Start = 1'b1; Op = 2'd2; A = 32'd50; B = 32'd7;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Start = 1'b1; Op = 2'd0; A = 32'd3; B = 32'd3; WrHi = 1'b1; WrData = 32'h0000_1234;
        tick();
        Start = 1'b0; WrHi = 1'b0;
        chk("busy ignores wrhi", Hi, 32'hCAFE_0001);
        edges = 5;
        seen = 1'b0;
        while (Done !== 1'b1 && edges < 100) begin
            if (Hi !== 32'hCAFE_0001 || Lo !== 32'hBEEF_0002 || Busy !== 1'b1) seen = 1'b1;
            tick();
            edges++;
        end
        chk("repulse hold", seen, 0);
        chk("repulse latency", edges, 33);
        chk("repulse hi", Hi, 32'd1);
        chk("repulse lo", Lo, 32'd7);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done === 1'b1) ndone++;
        end
        chk("repulse no second done", ndone, 0);
        chk("repulse idle", Busy, 0);
        cur_hi = 32'd1;
        cur_lo = 32'd7;

        // Direct write in the same cycle as Start, then overwritten by the result
        run_op("wr_with_start", 2'd1, 32'd6, 32'd9, 32'd0, 32'd54, 1'b0, 1'b1, 32'h5555_AAAA);

        // Reset mid-operation: aborted, no Done
        tick();
        Start = 1'b1; Op = 2'd0; A = 32'd11; B = 32'd13;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("abort busy", Busy, 0);
        chk("abort hi", Hi, 0);
        chk("abort lo", Lo, 0);
        chk("abort done", Done, 0);
        seen = 1'b0;
        for (int i = 11; i <= 40; i++) begin
            tick();
            if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
        end
        chk("abort no done", seen, 0);
        WrLo = 1'b1; WrData = 32'hA5A5_A5A5;
        tick();
        WrLo = 1'b0;
        chk("post-abort wrlo", Lo, 32'hA5A5_A5A5);
        chk("post-abort hi", Hi, 0);
        cur_hi = '0;
        cur_lo = 32'hA5A5_A5A5;

        // Random ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = pick_opnd();
            rb = pick_opnd();
            model(rop, ra, rb, mhi, mlo, mdz);
            run_op($sformatf("rnd%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, mhi, mlo, mdz, 1'b0, 32'd0);
            if ($urandom_range(0, 2) == 0) tick();
        end
        tick();
        chk("final done low", Done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
